// File: rtl/palette_pkg.sv
// palette_pkg: shared types, constants and the palette-rotation mapping used by
// the palette scheduler and its rotator. The PALETTE_CYCLE_EN build option is
// handled in palette_scheduler.
package palette_pkg;

  localparam int NUM_COLORS = 8;
  localparam int NUM_SUBPIX = 4;
  localparam int ROT_PERIOD = 7;

  typedef logic [$clog2(NUM_COLORS)-1:0] color_idx_t;
  typedef logic [$clog2(NUM_SUBPIX)-1:0] subpix_t;
  typedef logic [5:0]                    rgb6_t;

  // Rotation FSM: wait for a vsync rising edge, then wait for vsync to drop.
  typedef enum logic {
    WAIT_EDGE = 1'b0,
    WAIT_LOW  = 1'b1
  } rot_state_e;

  // Entry 0 is pinned; entries 1..7 form a ring of ROT_PERIOD that is
  // rotated by offset (0..6). The sum fits in 4 bits, so no overflow occurs.
  function automatic color_idx_t rotate_idx(input color_idx_t idx,
                                            input color_idx_t offset);
    logic [3:0] sum;
    color_idx_t res;
    sum = {1'b0, idx} - 4'd1 + {1'b0, offset};
    if (sum >= 4'(ROT_PERIOD)) begin
      sum = sum - 4'(ROT_PERIOD);
    end
    res = (idx == '0) ? '0 : color_idx_t'(sum + 4'd1);
    return res;
  endfunction

endpackage

// File: rtl/palette_rotator.sv
// palette_rotator: counts vsync rising edges and advances the palette rotation
// offset once every CYCLE_FRAMES frames, wrapping 6 -> 0. A vsync held high
// for many clocks counts as a single frame. Instantiated by palette_scheduler
// only when PALETTE_CYCLE_EN is defined.
module palette_rotator
  import palette_pkg::*;
#(
  parameter int CYCLE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  output color_idx_t rot_offset
);

  // A 1-frame period still needs a 1-bit counter so the ports stay legal.
  localparam int CNT_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(CYCLE_FRAMES - 1);
  localparam color_idx_t       LAST_OFFSET = color_idx_t'(ROT_PERIOD - 1);

  rot_state_e       state_q, state_d;
  logic             vsync_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  color_idx_t       rot_q, rot_d;
  logic             vsync_rise;

  assign vsync_rise = vsync & ~vsync_q;
  assign rot_offset = rot_q;

  // State, vsync history, frame counter and offset registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of every other register, independent of statement order.
    if (!rst_n) begin
      state_q     <= WAIT_EDGE;
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
      rot_q       <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      frame_cnt_q <= frame_cnt_d;
      rot_q       <= rot_d;
    end
  end

  // Next-state logic: one frame count per rising edge, offset step on wrap.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    rot_d       = rot_q;
    case (state_q)
      WAIT_EDGE: begin
        if (vsync_rise) begin
          state_d = WAIT_LOW;
          if (frame_cnt_q == LAST_FRAME) begin
            frame_cnt_d = '0;
            rot_d       = (rot_q == LAST_OFFSET) ? '0 : rot_q + 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      WAIT_LOW: begin
        if (!vsync) begin
          state_d = WAIT_EDGE;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

endmodule

// File: rtl/palette_scheduler.sv
// palette_scheduler: per-pixel front end of the shared 8-entry dithered palette
// LUT. Picks sprite or background index, derives the 2x2 dither subpixel,
// optionally rotates palette entries per frame, and registers the LUT result
// as 2-bit RGB. Input to RGB latency is 2 clocks at 1 pixel per clock.
// Build option: define PALETTE_CYCLE_EN to include the palette rotator;
// without it rot_offset is 0 and lut_index follows the selected index.
module palette_scheduler
  import palette_pkg::*;
#(
  parameter color_idx_t TRANSPARENT_IDX = 3'd0,
  parameter int         CYCLE_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       vsync,
  input  logic       spr_valid,
  input  logic [2:0] spr_index,
  input  logic [2:0] bg_index,
  output logic [2:0] lut_index,
  output logic [1:0] lut_subpixel,
  input  logic [1:0] lut_r,
  input  logic [1:0] lut_g,
  input  logic [1:0] lut_b,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic [2:0] rot_offset
);

  color_idx_t sel;
  subpix_t    subpix;
  color_idx_t lut_index_d, lut_index_q;
  subpix_t    lut_subpixel_q;
  logic       active_d1_q;
  rgb6_t      rgb_d, rgb_q;
  logic       unused_inputs;

  // Stage 0: a visible, non-transparent sprite always beats the background.
  assign sel    = (spr_valid && (spr_index != TRANSPARENT_IDX)) ? spr_index : bg_index;
  // Only the low bit of each coordinate selects the 2x2 dither cell.
  assign subpix = {pix_y[0], pix_x[0]};

`ifdef PALETTE_CYCLE_EN
  color_idx_t rot_w;

  palette_rotator #(
    .CYCLE_FRAMES(CYCLE_FRAMES)
  ) u_rotator (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .rot_offset(rot_w)
  );

  assign rot_offset    = rot_w;
  assign lut_index_d   = rotate_idx(sel, rot_w);
  assign unused_inputs = ^{pix_x[9:1], pix_y[9:1]};
`else
  // Without rotation the frame period has no consumer.
  localparam int unused_cycle_frames = CYCLE_FRAMES;

  assign rot_offset    = '0;
  assign lut_index_d   = sel;
  assign unused_inputs = ^{pix_x[9:1], pix_y[9:1], vsync};
`endif

  // Stage 1: register LUT address and carry the active flag alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_index_q    <= '0;
      lut_subpixel_q <= '0;
      active_d1_q    <= 1'b0;
    end else begin
      lut_index_q    <= lut_index_d;
      lut_subpixel_q <= subpix;
      active_d1_q    <= video_active;
    end
  end

  // Blanked pixels still address the LUT, but their colour is forced to black.
  always_comb begin
    rgb_d = '0;
    if (active_d1_q) begin
      rgb_d = {lut_r, lut_g, lut_b};
    end
  end

  // Stage 2: register the final pixel colour toward the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign lut_index    = lut_index_q;
  assign lut_subpixel = lut_subpixel_q;
  assign {r, g, b}    = rgb_q;

endmodule
